// File: rtl/fpnew_pkg.sv
// Shared FPU types: exception flags, operation codes, the writeback entry
// layout and the integer-destination classification.
package fpnew_pkg;

    // IEEE exception flags in fflags bit order: NV DZ OF UF NX (NX is bit 0)
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef enum logic [3:0] {
        FMADD    = 4'd0,
        FNMSUB   = 4'd1,
        ADD      = 4'd2,
        MUL      = 4'd3,
        DIV      = 4'd4,
        SQRT     = 4'd5,
        SGNJ     = 4'd6,
        MINMAX   = 4'd7,
        CMP      = 4'd8,
        CLASSIFY = 4'd9,
        F2F      = 4'd10,
        F2I      = 4'd11,
        I2F      = 4'd12,
        CPKAB    = 4'd13,
        CPKCD    = 4'd14
    } operation_e;

    // One queued writeback: result data, destination register, destination file
    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        is_int;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

    // Compares, classifies and float-to-int conversions land in the integer file
    function automatic logic writes_int(operation_e op);
        logic res;
        case (op)
            CMP, CLASSIFY, F2I: res = 1'b1;
            default:            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Circular result FIFO. The caller only pushes when there is room (or a pop
// frees a slot in the same cycle) and only pops when non-empty.
module fpu_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 38,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i) begin
            mem[wptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_i) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem[rptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;

endmodule

// File: rtl/fpu_wb_collector.sv
// Collects FPU responses into a FIFO and retires them in order to either the
// FP register file (fire-and-forget) or the integer writeback port (handshaked),
// while accruing sticky exception flags.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. fpu_ready_o may depend combinationally on int_ready_i (a retiring
// head frees its slot in the same cycle). int_valid_o, once high, holds its
// address and data until int_ready_i is seen high. fp_we_o has no back-pressure.
module fpu_wb_collector
    import fpnew_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          fpu_valid_i,
    output logic          fpu_ready_o,
    input  logic [31:0]   fpu_result_i,
    input  status_t       fpu_status_i,
    input  operation_e    fpu_op_i,
    input  logic [4:0]    fpu_tag_i,
    output logic          fp_we_o,
    output logic [4:0]    fp_waddr_o,
    output logic [31:0]   fp_wdata_o,
    output logic          int_valid_o,
    output logic [4:0]    int_waddr_o,
    output logic [31:0]   int_wdata_o,
    input  logic          int_ready_i,
    input  logic          csr_we_i,
    input  logic [4:0]    csr_wdata_i,
    output logic [4:0]    fflags_o,
    output logic [CW-1:0] count_o
);

    wb_entry_t   push_entry;
    wb_entry_t   head;
    logic [WB_ENTRY_W-1:0] head_bits;
    logic        empty;
    logic        full;
    logic        pop;
    logic        accept;
    logic [4:0]  status_bits;
    logic [4:0]  fflags_q;

    // Retire the head when it exists and its destination can take it; drive
    // the two writeback ports from the head; admit a new response when a slot
    // is free now or freed by this cycle's retirement. Everything is held off
    // during reset.
    always_comb begin
        push_entry.data   = fpu_result_i;
        push_entry.tag    = fpu_tag_i;
        push_entry.is_int = writes_int(fpu_op_i);
        head              = wb_entry_t'(head_bits);
        status_bits       = fpu_status_i;

        pop         = !rst_i && !empty && (!head.is_int || int_ready_i);
        fp_we_o     = !rst_i && !empty && !head.is_int;
        int_valid_o = !rst_i && !empty && head.is_int;
        fp_waddr_o  = head.tag;
        fp_wdata_o  = head.data;
        int_waddr_o = head.tag;
        int_wdata_o = head.data;

        fpu_ready_o = !rst_i && (!full || pop);
        accept      = fpu_valid_i && fpu_ready_o;
    end

    fpu_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WB_ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head_bits),
        .empty_o (empty),
        .full_o  (full),
        .count_o (count_o)
    );

    // Sticky flag accrual; a software write replaces the flags but still
    // merges in the status of a response accepted in the same cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fflags_q <= '0;
        end else if (csr_we_i) begin
            fflags_q <= csr_wdata_i | (accept ? status_bits : 5'b0);
        end else if (accept) begin
            fflags_q <= fflags_q | status_bits;
        end
    end

    assign fflags_o = fflags_q;

endmodule
